// File: rtl/ex_stage_unit_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, forwarding
// selects, mul/div engine state and a couple of small helpers.
package ex_pkg;

  localparam int XLEN     = 32;
  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = 5;
  localparam logic [MD_CNT_W-1:0] MD_CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REMU = 5'd18;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // True for the opcodes handled by the iterative engine.
  function automatic logic is_md_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // Operand forwarding select; the reserved code falls back to the regfile.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] wb,
                                              input logic [XLEN-1:0] exmem);
    case (sel)
      FWD_WB:    return wb;
      FWD_EXMEM: return exmem;
      default:   return rf;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_unit_md_engine.sv
// Iterative 32-step engine for MUL (low word), DIVU and REMU.
// start_i is honoured only in IDLE; operands are latched there, so the
// inputs may change freely while the engine is BUSY or DONE.
module md_engine
  import ex_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output md_state_e       state_o
);

  md_state_e             state_q;
  logic [4:0]            op_q;
  logic [XLEN-1:0]       acc_q;   // product accumulator, or partial remainder
  logic [XLEN-1:0]       x_q;     // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]       y_q;     // multiplier, or divisor
  logic [MD_CNT_W-1:0]   cnt_q;
  logic [XLEN:0]         rem_shift;
  logic [XLEN:0]         rem_diff;

  // Restoring-division trial subtraction; a set top bit means borrow.
  always_comb begin
    rem_shift = {acc_q, x_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, y_q};
  end

  // Engine FSM and datapath: latch in IDLE, one step per BUSY cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            x_q     <= a_i;
            y_q     <= b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (op_q == ALU_MUL) begin
            if (y_q[0]) acc_q <= acc_q + x_q;
            x_q <= x_q << 1;
            y_q <= y_q >> 1;
          end else if (!rem_diff[XLEN]) begin
            acc_q <= rem_diff[XLEN-1:0];
            x_q   <= {x_q[XLEN-2:0], 1'b1};
          end else begin
            acc_q <= rem_shift[XLEN-1:0];
            x_q   <= {x_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + MD_CNT_W'(1);
          if (cnt_q == MD_CNT_LAST) state_q <= MD_DONE;
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == MD_BUSY);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = (op_q == ALU_DIVU) ? x_q : acc_q;
  assign state_o  = state_q;

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch resolution,
// the iterative mul/div engine and the EX/MEM pipeline register.
// EX_Stall holds the front end while a mul/div op occupies EX.
module ex_stage_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_EX_PC,
  input  logic [31:0] ID_EX_read1_data,
  input  logic [31:0] ID_EX_read2_data,
  input  logic [63:0] ID_EX_imm,
  input  logic [4:0]  ID_EX_RD,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemtoReg,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_Branch,
  input  logic        ID_EX_ALUSrc,
  input  logic [4:0]  ID_EX_ALUOp,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] MEM_WB_WriteData,
  output logic        EX_Stall,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_WriteData,
  output logic [4:0]  EX_MEM_RD,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemtoReg,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_BranchTaken,
  output logic [31:0] EX_MEM_BranchTarget
);

  logic [31:0] op_a, fwd_b, op_b, alu_res;
  logic [4:0]  shamt;
  logic        md_start, md_busy, md_done;
  logic [31:0] md_result;
  md_state_e   md_state;
  logic        unused_imm_hi;

  logic [31:0] alu_q, wdata_q, target_q;
  logic [4:0]  rd_q, md_rd_q;
  logic        regw_q, m2r_q, memw_q, memr_q, bt_q;
  logic        md_regw_q, md_m2r_q, md_memw_q, md_memr_q;

  assign unused_imm_hi = ^ID_EX_imm[63:32];

  assign op_a  = fwd_sel(ForwardA, ID_EX_read1_data, MEM_WB_WriteData, alu_q);
  assign fwd_b = fwd_sel(ForwardB, ID_EX_read2_data, MEM_WB_WriteData, alu_q);
  assign op_b  = ID_EX_ALUSrc ? ID_EX_imm[31:0] : fwd_b;
  assign shamt = op_b[4:0];

  // Single-cycle ALU; unknown opcodes produce zero.
  always_comb begin
    alu_res = '0;
    case (ID_EX_ALUOp)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = 32'($signed(op_a) >>> shamt);
      ALU_SLT:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {31'b0, (op_a < op_b)};
      ALU_LUI:  alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  assign md_start = is_md_op(ID_EX_ALUOp) && (md_state == MD_IDLE);
  // Reset gates the stall so it drops the moment reset asserts.
  assign EX_Stall = rst && (md_start || md_busy);

  md_engine u_md (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (md_start),
    .op_i     (ID_EX_ALUOp),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result),
    .state_o  (md_state)
  );

  // Destination and control of the mul/div op, held until it retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_rd_q   <= '0;
      md_regw_q <= 1'b0;
      md_m2r_q  <= 1'b0;
      md_memw_q <= 1'b0;
      md_memr_q <= 1'b0;
    end else if (md_start) begin
      md_rd_q   <= ID_EX_RD;
      md_regw_q <= ID_EX_RegWrite;
      md_m2r_q  <= ID_EX_MemtoReg;
      md_memw_q <= ID_EX_MemWrite;
      md_memr_q <= ID_EX_MemRead;
    end
  end

  // EX/MEM register: engine result on DONE, bubble while stalled, else ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q <= '0; wdata_q <= '0; target_q <= '0; rd_q <= '0;
      regw_q <= 1'b0; m2r_q <= 1'b0; memw_q <= 1'b0; memr_q <= 1'b0; bt_q <= 1'b0;
    end else if (md_done) begin
      alu_q <= md_result; wdata_q <= '0; target_q <= '0; rd_q <= md_rd_q;
      regw_q <= md_regw_q; m2r_q <= md_m2r_q; memw_q <= md_memw_q; memr_q <= md_memr_q;
      bt_q <= 1'b0;
    end else if (md_start || md_busy) begin
      alu_q <= '0; wdata_q <= '0; target_q <= '0; rd_q <= '0;
      regw_q <= 1'b0; m2r_q <= 1'b0; memw_q <= 1'b0; memr_q <= 1'b0; bt_q <= 1'b0;
    end else begin
      alu_q    <= alu_res;
      wdata_q  <= fwd_b;
      target_q <= ID_EX_PC + ID_EX_imm[31:0];
      rd_q     <= ID_EX_RD;
      regw_q   <= ID_EX_RegWrite;
      m2r_q    <= ID_EX_MemtoReg;
      memw_q   <= ID_EX_MemWrite;
      memr_q   <= ID_EX_MemRead;
      bt_q     <= ID_EX_Branch && (op_a == op_b);
    end
  end

  assign EX_MEM_ALUResult    = alu_q;
  assign EX_MEM_WriteData    = wdata_q;
  assign EX_MEM_BranchTarget = target_q;
  assign EX_MEM_RD           = rd_q;
  assign EX_MEM_RegWrite     = regw_q;
  assign EX_MEM_MemtoReg     = m2r_q;
  assign EX_MEM_MemWrite     = memw_q;
  assign EX_MEM_MemRead      = memr_q;
  assign EX_MEM_BranchTaken  = bt_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: directed vectors with literal expectations plus an
// instruction-level model compared against the DUT on every falling edge.
module tb_ex_stage_unit;
  import ex_pkg::*;

  logic        clk, rst;
  logic [31:0] ID_EX_PC, ID_EX_read1_data, ID_EX_read2_data;
  logic [63:0] ID_EX_imm;
  logic [4:0]  ID_EX_RD, ID_EX_ALUOp;
  logic        ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemWrite, ID_EX_MemRead;
  logic        ID_EX_Branch, ID_EX_ALUSrc;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] MEM_WB_WriteData;
  logic        EX_Stall;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_BranchTarget;
  logic [4:0]  EX_MEM_RD;
  logic        EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_MemRead;
  logic        EX_MEM_BranchTaken;

  int n_assert = 0;
  int n_fail   = 0;

  ex_stage_unit dut (
    .clk(clk), .rst(rst),
    .ID_EX_PC(ID_EX_PC), .ID_EX_read1_data(ID_EX_read1_data),
    .ID_EX_read2_data(ID_EX_read2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_RD(ID_EX_RD),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .MEM_WB_WriteData(MEM_WB_WriteData),
    .EX_Stall(EX_Stall), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_RD(EX_MEM_RD),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_BranchTaken(EX_MEM_BranchTaken), .EX_MEM_BranchTarget(EX_MEM_BranchTarget)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- instruction-level model ----------------
  int          m_phase = 0;    // edges since a mul/div op was accepted; 0 = none
  logic [31:0] m_md_res = '0;
  logic [4:0]  m_md_rd = '0;
  logic        m_md_rw = 1'b0, m_md_m2r = 1'b0, m_md_mw = 1'b0, m_md_mr = 1'b0;
  int          e_kind = 0;     // 0 full ALU entry, 1 bubble, 2 mul/div result
  logic [31:0] e_alu = '0, e_wd = '0, e_tgt = '0;
  logic [4:0]  e_rd = '0;
  logic        e_rw = 1'b0, e_m2r = 1'b0, e_mw = 1'b0, e_mr = 1'b0, e_bt = 1'b0;
  logic [31:0] m_a, m_b, m_fb;

  function automatic logic m_is_md(input logic [4:0] op);
    return op == 5'd16 || op == 5'd17 || op == 5'd18;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return MEM_WB_WriteData;
    if (sel == 2'b10) return e_alu;
    return rf;
  endfunction

  function automatic logic [31:0] m_calc(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] prod;
    int sa, sb;
    sa = a; sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return sa >>> b[4:0];
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_LUI:  return b;
      ALU_MUL:  begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; e_kind = 0;
      e_alu = '0; e_wd = '0; e_tgt = '0; e_rd = '0;
      e_rw = 0; e_m2r = 0; e_mw = 0; e_mr = 0; e_bt = 0;
    end else if (m_phase == 0) begin
      m_a  = m_fwd(ForwardA, ID_EX_read1_data);
      m_fb = m_fwd(ForwardB, ID_EX_read2_data);
      m_b  = ID_EX_ALUSrc ? ID_EX_imm[31:0] : m_fb;
      if (m_is_md(ID_EX_ALUOp)) begin
        m_phase  = 1;
        m_md_res = m_calc(ID_EX_ALUOp, m_a, m_b);
        m_md_rd  = ID_EX_RD; m_md_rw = ID_EX_RegWrite; m_md_m2r = ID_EX_MemtoReg;
        m_md_mw  = ID_EX_MemWrite; m_md_mr = ID_EX_MemRead;
        e_kind = 1; e_rw = 0; e_mw = 0; e_mr = 0; e_bt = 0;
      end else begin
        e_kind = 0;
        e_alu  = m_calc(ID_EX_ALUOp, m_a, m_b);
        e_wd   = m_fb;
        e_tgt  = ID_EX_PC + ID_EX_imm[31:0];
        e_rd   = ID_EX_RD; e_rw = ID_EX_RegWrite; e_m2r = ID_EX_MemtoReg;
        e_mw   = ID_EX_MemWrite; e_mr = ID_EX_MemRead;
        e_bt   = ID_EX_Branch && (m_a == m_b);
      end
    end else if (m_phase < 33) begin
      m_phase = m_phase + 1;
      e_kind = 1; e_rw = 0; e_mw = 0; e_mr = 0; e_bt = 0;
    end else begin
      m_phase = 0; e_kind = 2;
      e_alu = m_md_res; e_rd = m_md_rd; e_rw = m_md_rw; e_m2r = m_md_m2r;
      e_mw = m_md_mw; e_mr = m_md_mr; e_bt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = rst && ((m_phase == 0 && m_is_md(ID_EX_ALUOp)) ||
                        (m_phase >= 1 && m_phase <= 32));
    check("stall", 32'(EX_Stall), 32'(exp_stall));
    check("regwrite", 32'(EX_MEM_RegWrite), 32'(e_rw));
    check("memwrite", 32'(EX_MEM_MemWrite), 32'(e_mw));
    check("memread", 32'(EX_MEM_MemRead), 32'(e_mr));
    check("branch_taken", 32'(EX_MEM_BranchTaken), 32'(e_bt));
    if (e_kind != 1) begin
      check("alu_result", EX_MEM_ALUResult, e_alu);
      check("rd", 32'(EX_MEM_RD), 32'(e_rd));
      check("memtoreg", 32'(EX_MEM_MemtoReg), 32'(e_m2r));
    end
    if (e_kind == 0) begin
      check("write_data", EX_MEM_WriteData, e_wd);
      check("branch_target", EX_MEM_BranchTarget, e_tgt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nop();
    ID_EX_PC = '0; ID_EX_read1_data = '0; ID_EX_read2_data = '0; ID_EX_imm = '0;
    ID_EX_RD = '0; ID_EX_ALUOp = ALU_ADD; ID_EX_RegWrite = 0; ID_EX_MemtoReg = 0;
    ID_EX_MemWrite = 0; ID_EX_MemRead = 0; ID_EX_Branch = 0; ID_EX_ALUSrc = 0;
    ForwardA = FWD_RF; ForwardB = FWD_RF; MEM_WB_WriteData = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    nop();
    ID_EX_ALUOp = op; ID_EX_read1_data = a; ID_EX_read2_data = b;
    ID_EX_RD = rd; ID_EX_RegWrite = 1'b1;
  endtask

  // Counts stalled cycles of a mul/div op (first cycle already driven),
  // scrambling operand sources after acceptance. Returns in the DONE cycle.
  task automatic wait_md(output int n);
    n = 0;
    forever begin
      #1;
      if (!EX_Stall || n > 40) break;
      n++;
      @(posedge clk);
      #1;
      ID_EX_read1_data = $urandom; ID_EX_read2_data = $urandom;
      ForwardA = 2'($urandom_range(0, 3)); ForwardB = 2'($urandom_range(0, 3));
      MEM_WB_WriteData = $urandom;
    end
  endtask

  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_op(op, a, b, 5'd7);
    wait_md(n);
    check({name, "_stall_cycles"}, n, 33);
    nop();
    tick();
    check(name, EX_MEM_ALUResult, exp);
    check({name, "_rd"}, 32'(EX_MEM_RD), 32'd7);
    check({name, "_regwrite"}, 32'(EX_MEM_RegWrite), 32'd1);
  endtask

  typedef struct { logic [4:0] op; logic [31:0] a, b, exp; } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    nop();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu", EX_MEM_ALUResult, 32'd0);
    check("reset_regwrite", 32'(EX_MEM_RegWrite), 32'd0);
    check("reset_stall", 32'(EX_Stall), 32'd0);
    rst = 1'b1;
    tick();

    set_op(ALU_ADD, 32'd7, 32'd5, 5'd3);
    tick();
    check("add_7_5", EX_MEM_ALUResult, 32'd12);
    check("add_rd", 32'(EX_MEM_RD), 32'd3);
    check("add_regwrite", 32'(EX_MEM_RegWrite), 32'd1);
    check("add_stall", 32'(EX_Stall), 32'd0);

    set_op(ALU_ADD, 32'h80, 32'h80, 5'd4);
    tick();
    set_op(ALU_ADD, 32'hDEAD, 32'd0, 5'd5);
    ForwardA = FWD_EXMEM; ID_EX_ALUSrc = 1'b1; ID_EX_imm = 64'd4;
    tick();
    check("fwd_exmem_imm", EX_MEM_ALUResult, 32'h104);

    set_op(ALU_ADD, 32'h1000, 32'h1111, 5'd0);
    ID_EX_RegWrite = 0; ID_EX_MemWrite = 1; ID_EX_ALUSrc = 1; ID_EX_imm = 64'd8;
    ForwardB = FWD_WB; MEM_WB_WriteData = 32'h55AA;
    tick();
    check("store_addr", EX_MEM_ALUResult, 32'h1008);
    check("store_data_fwd_wb", EX_MEM_WriteData, 32'h55AA);

    vecs.push_back(mk(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE));
    vecs.push_back(mk(ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000));
    vecs.push_back(mk(ALU_OR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0));
    vecs.push_back(mk(ALU_XOR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0));
    vecs.push_back(mk(ALU_SLL, 32'd1, 32'h24, 32'h10));
    vecs.push_back(mk(ALU_SRL, 32'h8000_0000, 32'd31, 32'd1));
    vecs.push_back(mk(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000));
    vecs.push_back(mk(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1));
    vecs.push_back(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0));
    vecs.push_back(mk(ALU_LUI, 32'h1234, 32'hABCD_E000, 32'hABCD_E000));
    vecs.push_back(mk(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1));
    vecs.push_back(mk(5'd12, 32'd9, 32'd9, 32'd0));
    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'd9);
      tick();
      check("alu_vec", EX_MEM_ALUResult, vecs[i].exp);
      check("alu_vec_regwrite", 32'(EX_MEM_RegWrite), 32'd1);
    end

    nop();
    ID_EX_Branch = 1; ID_EX_PC = 32'h40; ID_EX_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    ID_EX_read1_data = 32'd3; ID_EX_read2_data = 32'd3;
    tick();
    check("branch_taken_eq", 32'(EX_MEM_BranchTaken), 32'd1);
    check("branch_target", EX_MEM_BranchTarget, 32'h38);
    ID_EX_read2_data = 32'd4;
    tick();
    check("branch_taken_ne", 32'(EX_MEM_BranchTaken), 32'd0);

    run_md("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    run_md("divu_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_md("remu_0", ALU_REMU, 32'd5, 32'd0, 32'd5);

    // Back-to-back: REMU enters EX in the DONE cycle of DIVU.
    set_op(ALU_DIVU, 32'd100, 32'd7, 5'd7);
    wait_md(n);
    check("divu_stall_cycles", n, 33);
    set_op(ALU_REMU, 32'd100, 32'd7, 5'd7);
    tick();
    check("divu_100_7", EX_MEM_ALUResult, 32'd14);
    check("b2b_stall", 32'(EX_Stall), 32'd1);
    wait_md(n);
    check("remu_stall_cycles", n, 33);
    nop();
    tick();
    check("remu_100_7", EX_MEM_ALUResult, 32'd2);

    // Reset during BUSY cycle 10 of a MUL.
    set_op(ALU_MUL, 32'd3, 32'd4, 5'd11);
    repeat (11) tick();
    check("busy_stall", 32'(EX_Stall), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_stall", 32'(EX_Stall), 32'd0);
    check("midreset_alu", EX_MEM_ALUResult, 32'd0);
    check("midreset_regwrite", 32'(EX_MEM_RegWrite), 32'd0);
    nop();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_md("divu_after_reset", ALU_DIVU, 32'd100, 32'd7, 32'd14);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
